phy_lane_scheduler: RTL and testbench

//  Controller ahead of the PHY byte datapath. Shares one 8-bit symbol stream between

---
 rtl/phy_lane_scheduler_pkg.sv | 15 +
 rtl/phy_lane_scheduler_arb.sv | 32 +++
 rtl/phy_lane_scheduler.sv | 120 ++++++++++++
 tb/tb_phy_lane_scheduler.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/phy_lane_scheduler_pkg.sv
// Shared line-symbol constants and link state encodings for the PHY byte path.
// The serializer and receiver align on these same values.
package phy_lane_scheduler_pkg;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_TRAIN    = 2'b01,
    ST_ACTIVE   = 2'b10
  } state_t;

endpackage

// File: rtl/phy_lane_scheduler_arb.sv
// Four-way round-robin arbiter, purely combinational: the search starts at the
// lane after the last one granted and wraps around.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] idx;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    if (en) begin
      for (int i = 1; i <= 4; i++) begin
        idx = last + 2'(i);
        if (!any && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_id   = idx;
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_lane_scheduler.sv
// Link sequencer and lane scheduler ahead of the PHY byte datapath:
// DISABLED -> TRAIN (COM burst) -> ACTIVE with round-robin lane data and periodic SKP.
module phy_lane_scheduler
  import phy_lane_scheduler_pkg::*;
#(
  parameter int TRAIN_LEN    = 16,
  parameter int SKP_INTERVAL = 64,
  parameter int CNT_W        = 7
) (
  input  logic       clk4f,
  input  logic       reset,
  input  logic       link_en,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] validin,
  output logic [3:0] ready,
  output logic [7:0] out_data,
  output logic       out_k,
  output logic       out_valid,
  output logic [1:0] out_lane,
  output logic [1:0] state
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       last;
  logic             skp_cycle;
  logic             arb_en;
  logic [3:0]       gnt;
  logic [1:0]       gnt_id;
  logic             any;
  logic [7:0]       gnt_data;

  // A pending SKP and a dropping link_en both suppress the grant in this cycle.
  assign skp_cycle = (cnt == CNT_W'(SKP_INTERVAL - 1));
  assign arb_en    = (state_q == ST_ACTIVE) && link_en && !skp_cycle;

  rr_arbiter4 u_arb (
    .req    (validin),
    .last   (last),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign ready = gnt;
  assign state = state_q;

  always_comb begin
    case (gnt_id)
      2'd0:    gnt_data = in0;
      2'd1:    gnt_data = in1;
      2'd2:    gnt_data = in2;
      default: gnt_data = in3;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk4f) begin
    if (reset) begin
      state_q   <= ST_DISABLED;
      cnt       <= '0;
      last      <= 2'd3;
      out_data  <= IDL;
      out_k     <= 1'b1;
      out_valid <= 1'b0;
      out_lane  <= 2'd0;
    end else begin
      out_data  <= IDL;
      out_k     <= 1'b1;
      out_valid <= 1'b0;
      case (state_q)
        ST_TRAIN: begin
          if (!link_en) begin
            state_q <= ST_DISABLED;
            cnt     <= '0;
          end else if (cnt == CNT_W'(TRAIN_LEN - 1)) begin
            state_q <= ST_ACTIVE;
            cnt     <= '0;
          end else begin
            cnt      <= cnt + CNT_W'(1);
            out_data <= COM;
          end
        end
        ST_ACTIVE: begin
          if (!link_en) begin
            state_q <= ST_DISABLED;
            cnt     <= '0;
          end else if (skp_cycle) begin
            cnt      <= '0;
            out_data <= SKP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (any) begin
              out_data  <= gnt_data;
              out_k     <= 1'b0;
              out_valid <= 1'b1;
              out_lane  <= gnt_id;
              last      <= gnt_id;
            end
          end
        end
        default: begin
          // The unused encoding behaves exactly like DISABLED.
          cnt <= '0;
          if (link_en) begin
            state_q  <= ST_TRAIN;
            out_data <= COM;
          end else begin
            state_q <= ST_DISABLED;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_lane_scheduler.sv
// Directed bench for phy_lane_scheduler: reset, training burst, round-robin,
// SKP insertion, link drop and mid-stream reset.
module tb_phy_lane_scheduler;

  logic       clk4f = 1'b0;
  logic       reset;
  logic       link_en;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] validin;
  logic [3:0] ready;
  logic [7:0] out_data;
  logic       out_k;
  logic       out_valid;
  logic [1:0] out_lane;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  phy_lane_scheduler dut (
    .clk4f     (clk4f),
    .reset     (reset),
    .link_en   (link_en),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .validin   (validin),
    .ready     (ready),
    .out_data  (out_data),
    .out_k     (out_k),
    .out_valid (out_valid),
    .out_lane  (out_lane),
    .state     (state)
  );

  always #5 clk4f = ~clk4f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check ready for the current inputs, clock once, then check the registered outputs.
  task automatic step(input string tag, input logic [3:0] exp_rdy, input logic [7:0] exp_data,
                      input logic exp_k, input logic exp_valid, input logic [1:0] exp_lane,
                      input logic [1:0] exp_state);
    #1;
    check({tag, ".ready"}, 32'(ready), 32'(exp_rdy));
    @(posedge clk4f);
    #1;
    check({tag, ".data"},  32'(out_data),  32'(exp_data));
    check({tag, ".k"},     32'(out_k),     32'(exp_k));
    check({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    check({tag, ".state"}, 32'(state),     32'(exp_state));
    if (exp_valid) check({tag, ".lane"}, 32'(out_lane), 32'(exp_lane));
  endtask

  // Starting in DISABLED with link_en high: 16 COM cycles, then ACTIVE showing IDL.
  task automatic train_burst(input string tag);
    for (int i = 0; i < 16; i++) step({tag, ".com"}, 4'b0000, 8'hBC, 1'b1, 1'b0, 2'd0, 2'b01);
    step({tag, ".enter"}, 4'b0000, 8'h7C, 1'b1, 1'b0, 2'd0, 2'b10);
  endtask

  initial begin
    logic [7:0] lane_byte [4];
    int         cnt_m;
    int         last_m;
    int         skps;

    lane_byte[0] = 8'hA0; lane_byte[1] = 8'hA1; lane_byte[2] = 8'hA2; lane_byte[3] = 8'hA3;
    reset = 1'b1; link_en = 1'b0; validin = 4'b0000;
    in0 = 8'hA0; in1 = 8'hA1; in2 = 8'hA2; in3 = 8'hA3;

    // 1: reset and idle DISABLED
    repeat (3) @(posedge clk4f);
    #1;
    check("rst.data",  32'(out_data),  32'h7C);
    check("rst.k",     32'(out_k),     32'd1);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.state", 32'(state),     32'd0);
    check("rst.ready", 32'(ready),     32'd0);
    reset = 1'b0;
    step("dis", 4'b0000, 8'h7C, 1'b1, 1'b0, 2'd0, 2'b00);

    // 2: training burst; ACTIVE cycle 0 with no requests
    link_en = 1'b1;
    train_burst("train1");
    step("act_idle", 4'b0000, 8'h7C, 1'b1, 1'b0, 2'd0, 2'b10);

    // 3: all lanes requesting, ACTIVE cycles 1..5
    validin = 4'b1111;
    step("rr0", 4'b0001, 8'hA0, 1'b0, 1'b1, 2'd0, 2'b10);
    step("rr1", 4'b0010, 8'hA1, 1'b0, 1'b1, 2'd1, 2'b10);
    step("rr2", 4'b0100, 8'hA2, 1'b0, 1'b1, 2'd2, 2'b10);
    step("rr3", 4'b1000, 8'hA3, 1'b0, 1'b1, 2'd3, 2'b10);
    step("rr4", 4'b0001, 8'hA0, 1'b0, 1'b1, 2'd0, 2'b10);

    // 4: sparse requests, ACTIVE cycles 6..11
    step("sp_l1", 4'b0010, 8'hA1, 1'b0, 1'b1, 2'd1, 2'b10);
    validin = 4'b1010;
    step("sp_l3", 4'b1000, 8'hA3, 1'b0, 1'b1, 2'd3, 2'b10);
    step("sp_l1b", 4'b0010, 8'hA1, 1'b0, 1'b1, 2'd1, 2'b10);
    validin = 4'b0010;
    for (int i = 0; i < 3; i++) step("solo_l1", 4'b0010, 8'hA1, 1'b0, 1'b1, 2'd1, 2'b10);

    // 5: continuous requests through ACTIVE cycle 130; SKP cycles at counter 63
    validin = 4'b1111;
    cnt_m = 12; last_m = 1; skps = 0;
    for (int cyc = 12; cyc <= 130; cyc++) begin
      if (cnt_m == 63) begin
        step("skp", 4'b0000, 8'h1C, 1'b1, 1'b0, 2'd0, 2'b10);
        if (out_data == 8'h1C && out_k) skps++;
        cnt_m = 0;
      end else begin
        last_m = (last_m + 1) % 4;
        step("rr_long", 4'(1 << last_m), lane_byte[last_m], 1'b0, 1'b1, 2'(last_m), 2'b10);
        cnt_m++;
      end
    end
    check("skp_count", 32'(skps), 32'd2);

    // link drop in ACTIVE: no grant, next output IDL, state DISABLED
    link_en = 1'b0;
    step("drop", 4'b0000, 8'h7C, 1'b1, 1'b0, 2'd0, 2'b00);

    // 6: retrain, stream, then a reset pulse mid-stream
    link_en = 1'b1;
    train_burst("train2");
    step("re_l3", 4'b1000, 8'hA3, 1'b0, 1'b1, 2'd3, 2'b10);
    step("re_l0", 4'b0001, 8'hA0, 1'b0, 1'b1, 2'd0, 2'b10);
    reset = 1'b1;
    @(posedge clk4f);
    #1;
    reset = 1'b0;
    link_en = 1'b0;
    #1;
    check("mid_rst.data",  32'(out_data),  32'h7C);
    check("mid_rst.valid", 32'(out_valid), 32'd0);
    check("mid_rst.state", 32'(state),     32'd0);
    check("mid_rst.ready", 32'(ready),     32'd0);
    link_en = 1'b1;
    train_burst("train3");
    step("post_rst_l0", 4'b0001, 8'hA0, 1'b0, 1'b1, 2'd0, 2'b10);
    step("post_rst_l1", 4'b0010, 8'hA1, 1'b0, 1'b1, 2'd1, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
